// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register map, LSR bits, FSM.
// UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

  localparam logic [7:0] RBR_OFF = 8'h00;
  localparam logic [7:0] LSR_OFF = 8'h05;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; push into a full FIFO is accepted only with a
// same-cycle pop, which frees the slot being written.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_regs.sv
// UART receiver with 16x oversampling, RX FIFO and RBR/LSR registers.
// UART_RX_PARITY_EN selects 8E1 framing with parity check.
module uart_rx_regs
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic        ren,
  input  logic [7:0]  raddr,
  output logic [63:0] rdata,
  output logic        irq
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  rx_state_e   state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        hold_q, hold_d;
  logic        rx_s1_q, rx_s2_q;
  logic        oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
  logic [63:0] rdata_q, rdata_d;
  logic        tick_en, push, pop, fe_set, pe_set, oe_set;
  logic        rd_rbr, rd_lsr;
  logic        f_full, f_empty;
  logic [7:0]  f_head, lsr;

  assign tick_en = (div_q == DIV_MAX);
  assign rd_rbr  = ren && (raddr == RBR_OFF);
  assign rd_lsr  = ren && (raddr == LSR_OFF);
  assign pop     = rd_rbr && !f_empty;
  assign oe_set  = push && f_full && !pop;
  assign rdata   = rdata_q;
  assign irq     = !f_empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .full  (f_full),
    .empty (f_empty),
    .head  (f_head)
  );

  // Two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Frame FSM: tick divider, oversample counter, bit shifter
  always_comb begin
    state_d = state_q;
    div_d   = tick_en ? '0 : div_q + DW'(1);
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    pe_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s2_q) begin
          state_d = ST_START;
          div_d   = '0;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (tick_en) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd7) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s2_q ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick_en) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {rx_s2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_d = ST_PARITY;
`else
            if (bit_q == 3'd7) state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_en) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            pe_set  = (rx_s2_q != ^shift_q);
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (hold_q) begin
          if (rx_s2_q) begin
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (tick_en) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            if (rx_s2_q) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              fe_set = 1'b1;
              hold_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags and registered read data
  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = !f_empty;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_PE]   = pe_q;
    lsr[LSR_FE]   = fe_q;
    lsr[LSR_THRE] = 1'b1;
    lsr[LSR_TEMT] = 1'b1;
    oe_d = (oe_q && !rd_lsr) || oe_set;
    pe_d = (pe_q && !rd_lsr) || pe_set;
    fe_d = (fe_q && !rd_lsr) || fe_set;
    rdata_d = rdata_q;
    if (ren) begin
      unique case (1'b1)
        rd_rbr:  rdata_d = {56'h0, f_empty ? 8'h00 : f_head};
        rd_lsr:  rdata_d = {56'h0, lsr};
        default: rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= 1'b0;
      oe_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      oe_q    <= oe_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_regs.sv
// Self-checking bench for uart_rx_regs (CLK_DIV=4, one bit = 64 clk).
// Define UART_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_rx_regs;

  localparam int BIT   = 64;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, rxd, ren;
  logic [7:0]  raddr;
  logic [63:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_oe, m_pe, m_fe;

  uart_rx_regs #(.CLK_DIV(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_oe = 0;
    m_pe = 0;
    m_fe = 0;
  endtask

  function automatic logic [63:0] model_lsr();
    logic [7:0] v;
    v = 8'h60;
    v[0] = (mq.size() != 0);
    v[1] = m_oe;
    v[2] = m_pe;
    v[3] = m_fe;
    return {56'h0, v};
  endfunction

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par_ok);
    logic par;
    par = par_ok ? ^b : ~^b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
    if (!par_ok) m_pe = 1;
`else
    if (par) begin end
`endif
    drive_bit(stop);
    if (!stop) begin
      m_fe = 1;
      drive_bit(1'b1);
    end else if (mq.size() >= DEPTH) begin
      m_oe = 1;
    end else begin
      mq.push_back(b);
    end
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [63:0] d);
    ren   = 1'b1;
    raddr = a;
    @(negedge clk);
    ren   = 1'b0;
    raddr = 8'h00;
    d     = rdata;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset = 1; rxd = 1; ren = 0; raddr = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    model_clear();
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h60) begin
      errors++;
      $display("FAIL reset_lsr got %h want 60", d);
    end
    read_reg(8'h00, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL reset_rbr_empty got %h want 0", d);
    end
  endtask

  task automatic test_single_byte();
    logic [63:0] d;
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL single_irq got %b want 1", irq);
    end
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h61) begin
      errors++;
      $display("FAIL single_lsr got %h want 61", d);
    end
    read_reg(8'h00, d);
    checks++;
    if (d !== 64'hA5) begin
      errors++;
      $display("FAIL single_rbr got %h want a5", d);
    end
    void'(mq.pop_front());
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h60) begin
      errors++;
      $display("FAIL single_lsr2 got %h want 60", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL single_irq2 got %b want 0", irq);
    end
    read_reg(8'h13, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL other_offset got %h want 0", d);
    end
  endtask

  task automatic test_false_start();
    logic [63:0] d;
    rxd = 0;
    repeat (20) @(negedge clk);
    rxd = 1;
    repeat (2 * BIT) @(negedge clk);
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h60) begin
      errors++;
      $display("FAIL false_start_lsr got %h want 60", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL false_start_irq got %b want 0", irq);
    end
  endtask

  task automatic test_framing_error();
    logic [63:0] d;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h68) begin
      errors++;
      $display("FAIL fe_lsr got %h want 68", d);
    end
    m_fe = 0;
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h60) begin
      errors++;
      $display("FAIL fe_lsr2 got %h want 60", d);
    end
    read_reg(8'h00, d);
    checks++;
    if (d !== 64'h0) begin
      errors++;
      $display("FAIL fe_rbr got %h want 0", d);
    end
  endtask

  task automatic test_overrun();
    logic [63:0] d;
    logic [7:0]  w;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h63) begin
      errors++;
      $display("FAIL ovr_lsr got %h want 63", d);
    end
    m_oe = 0;
    for (int i = 1; i <= 9; i++) begin
      w = (mq.size() != 0) ? mq.pop_front() : 8'h00;
      read_reg(8'h00, d);
      checks++;
      if (d !== {56'h0, w} || (i == 9 && w != 0)
          || (i < 9 && w != 8'(i))) begin
        errors++;
        $display("FAIL ovr_rbr%0d got %h want %h", i, d, w);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ovr_irq got %b want 0", irq);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] d;
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    model_clear();
    repeat (5) drive_bit(1'b1);
    send_frame(8'h42, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h61) begin
      errors++;
      $display("FAIL rst_mid_lsr got %h want 61", d);
    end
    read_reg(8'h00, d);
    checks++;
    if (d !== 64'h42) begin
      errors++;
      $display("FAIL rst_mid_rbr got %h want 42", d);
    end
    void'(mq.pop_front());
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h60) begin
      errors++;
      $display("FAIL rst_mid_lsr2 got %h want 60", d);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [63:0] d;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    read_reg(8'h05, d);
    checks++;
    if (d !== 64'h65) begin
      errors++;
      $display("FAIL parity_lsr got %h want 65", d);
    end
    m_pe = 0;
    read_reg(8'h00, d);
    checks++;
    if (d !== 64'h07) begin
      errors++;
      $display("FAIL parity_rbr got %h want 07", d);
    end
    void'(mq.pop_front());
  endtask
`endif

  task automatic test_random();
    logic [63:0] d, exp;
    logic [7:0]  w;
    int          n, k;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        send_frame(8'($urandom), ($urandom_range(0, 5) != 0),
                   ($urandom_range(0, 3) != 0));
      repeat (20) @(negedge clk);
      exp = model_lsr();
      read_reg(8'h05, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL rnd%0d_lsr got %h want %h", r, d, exp);
      end
      m_oe = 0; m_pe = 0; m_fe = 0;
      k = mq.size() + 1;
      for (int i = 0; i < k; i++) begin
        w = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        read_reg(8'h00, d);
        checks++;
        if (d !== {56'h0, w}) begin
          errors++;
          $display("FAIL rnd%0d_rbr%0d got %h want %h", r, i, d, w);
        end
      end
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_irq got %b want 0", r, irq);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_regs.md
UART_RX_REGS -- requirements
Module: uart_rx_regs

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27: clk cycles per 16x-oversample tick (min 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries (power of two, ≥2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port ren  input  1  register read strobe.
REQ-007 SHALL have port raddr  input  8  register byte offset.
REQ-008 SHALL have port rdata  output  64  read data, zero-extended byte.
REQ-009 SHALL have port irq  output  1  level interrupt, high while FIFO non-empty.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer before any use.
REQ-011 SHALL generate one oversample tick every CLK_DIV clk; 16 ticks = 1 bit time; frame = 8N1, LSB first.
REQ-012 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-013 IDLE: synchronized rxd low -> START; restart tick phase at that cycle.
REQ-014 START: sample at tick 8; low -> DATA; high -> IDLE (false start, nothing recorded).
REQ-015 DATA: sample every 16 ticks after the start mid-point; 8 samples -> STOP.
REQ-016 STOP: sample high -> push byte to FIFO, -> IDLE; sample low -> set FE, discard byte, stay until rxd high, then -> IDLE.
REQ-017 Push when FIFO full and no same-cycle pop -> byte dropped, OE set; push+pop same cycle when full -> both succeed, no OE.
REQ-018 Registers: offset 0x00 RBR (read pops FIFO head); offset 0x05 LSR; all other offsets read 0.
REQ-019 LSR bits: [0] DR=FIFO non-empty, [1] OE, [2] PE, [3] FE, [5] THRE=1, [6] TEMT=1; others 0.
REQ-020 LSR read SHALL return current flags, then clear OE/PE/FE; a flag set in the same cycle survives.
REQ-021 rdata SHALL be registered: value for a ren in cycle N appears after posedge N, held until the next ren.
REQ-022 RBR read when empty returns 0, no pop, no flag change.
REQ-023 irq SHALL equal LSR.DR from registered state.

Reset
REQ-024 On reset: FSM IDLE, tick/bit counters 0, synchronizer flops 1, FIFO empty, OE/PE/FE 0, rdata 0, irq 0.
REQ-025 Reset mid-frame aborts the frame; no partial byte is pushed.

Configuration
REQ-026 With UART_RX_PARITY_EN defined: frame 8E1, parity bit sampled between DATA and STOP (state PARITY); mismatch sets PE, byte still pushed.
REQ-027 Without UART_RX_PARITY_EN: frame 8N1, no PARITY state, LSR.PE constant 0.

Structure
REQ-028 Package uart_pkg SHALL hold register offsets (RBR, LSR), LSR bit indices, FSM state enum.
REQ-029 FIFO SHALL be sub-module uart_rx_fifo (push/pop/full/empty/head, synchronous reset); rest stays in uart_rx_regs.

Verification (CLK_DIV=4, bit = 64 clk)
REQ-030 Send 0xA5 8N1, idle, read 0x05 then 0x00 -> LSR 0x61, rdata 0x00000000000000A5, then LSR 0x60, irq 0.
REQ-031 Low pulse of 20 clk on idle line -> no push, LSR 0x60.
REQ-032 Send 0x3C with stop bit held low -> LSR 0x68; second LSR read 0x60; FIFO empty.
REQ-033 Send 9 bytes 0x01..0x09, no reads -> LSR 0x63; 8 RBR reads return 0x01..0x08, ninth RBR read 0.
REQ-034 Assert reset at bit 4 of frame 0xFF, release, send 0x42 -> only 0x42 received, flags 0.
REQ-035 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> LSR 0x65, RBR 0x07.
